visreader: RTL and testbench

Receive-side endpoint for the correlator chain's visibility output stream. Captures each accumulated frame of `vis_*` words into a two-bank buffer and re-emits it as a ready/valid stream of packed `{real, imag}` words with an end-of-frame marker, for the host/readout path. Capture and readout overlap, so the chain is never stalled. Frames arriving while both banks are still occupied are dropped, and the drop is flagged.

---
 rtl/visreader.sv | 227 ++++++++++++++++++++++
 tb/tb_visreader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/visreader.sv
// visreader: captures correlator visibility frames into two banks and re-emits them as a ready/valid stream.
// Optional `VISREADER_DROP_COUNT_EN adds drops_o, a saturating count of dropped frames.
//
// state   | meaning
// W_IDLE  | waiting for the first word of a frame
// W_FILL  | storing words of the current frame into the write bank
// W_DROP  | discarding a frame that found its bank still occupied
// R_IDLE  | waiting for the read bank to become full
// R_FETCH | word 0 sits in the SRAM register; it moves to the output next
// R_SEND  | output valid, advancing one word per handshake
module visreader #(
  parameter int WIDTH = 7,
  parameter int COUNT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vis_frame_i,
  input  logic               vis_valid_i,
  input  logic               vis_first_i,
  input  logic               vis_last_i,
  input  logic [WIDTH-1:0]   vis_real_i,
  input  logic [WIDTH-1:0]   vis_imag_i,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [2*WIDTH-1:0] m_tdata,
  output logic               overflow_o
`ifdef VISREADER_DROP_COUNT_EN
  ,
  output logic [7:0]         drops_o
`endif
);
  localparam int ABITS = $clog2(COUNT);
  localparam int IBITS = $clog2(2 * COUNT);
  localparam int DW    = 2 * WIDTH;
  localparam logic [ABITS:0] LEN_MAX = (ABITS+1)'(COUNT);
  localparam logic [ABITS:0] LEN_ONE = (ABITS+1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_t;

  logic [DW-1:0]  r_mem [2*COUNT];
  logic [DW-1:0]  r_q;
  wstate_t        r_wstate, w_wstate_n;
  logic           r_wbank, w_wbank_n;
  logic [ABITS:0] r_wcnt, w_wcnt_n;
  logic [1:0]     r_full;
  logic [ABITS:0] r_len [2];
  logic           r_overflow;
  rstate_t        r_rstate, w_rstate_n;
  logic           r_rbank;
  logic [ABITS:0] r_rptr, r_oidx, w_oidx_n;
  logic [DW-1:0]  r_tdata;
  logic           r_tvalid, r_tlast;

  logic           w_acc, w_start, w_sbank, w_sfree, w_rel, w_drop;
  logic [1:0]     w_commit;
  logic [ABITS:0] w_clen [2];
  logic           w_mem_we;
  logic [IBITS-1:0] w_mem_idx;
  logic           w_re, w_rbank_sel, w_load;
  logic [ABITS:0] w_raddr;

  function automatic logic [IBITS-1:0] f_idx(input logic b, input logic [ABITS:0] a);
    return b ? IBITS'(COUNT) + IBITS'(a) : IBITS'(a);
  endfunction

  // A new frame in W_FILL first commits the partial frame, so it lands in the other bank.
  assign w_acc   = vis_valid_i && vis_frame_i;
  assign w_start = w_acc && vis_first_i && (r_wstate != W_DROP);
  assign w_sbank = (r_wstate == W_FILL) ? ~r_wbank : r_wbank;
  assign w_sfree = !r_full[w_sbank] || (w_rel && (r_rbank == w_sbank));

  always_comb begin
    w_wstate_n = r_wstate;
    w_wbank_n  = r_wbank;
    w_wcnt_n   = r_wcnt;
    w_commit   = '0;
    w_clen[0]  = '0;
    w_clen[1]  = '0;
    w_mem_we   = 1'b0;
    w_mem_idx  = f_idx(r_wbank, r_wcnt);
    w_drop     = 1'b0;
    if (w_start) begin
      if (r_wstate == W_FILL) begin
        w_commit[r_wbank] = 1'b1;
        w_clen[r_wbank]   = r_wcnt;
      end
      w_wbank_n = w_sbank;
      if (w_sfree) begin
        w_mem_we  = 1'b1;
        w_mem_idx = f_idx(w_sbank, '0);
        w_wcnt_n  = LEN_ONE;
        if (vis_last_i) begin
          w_commit[w_sbank] = 1'b1;
          w_clen[w_sbank]   = LEN_ONE;
          w_wbank_n         = ~w_sbank;
          w_wstate_n        = W_IDLE;
        end else begin
          w_wstate_n = W_FILL;
        end
      end else begin
        w_drop     = 1'b1;
        w_wstate_n = vis_last_i ? W_IDLE : W_DROP;
      end
    end else if (w_acc && (r_wstate == W_FILL)) begin
      if (r_wcnt < LEN_MAX) begin
        w_mem_we = 1'b1;
        w_wcnt_n = r_wcnt + LEN_ONE;
      end
      if (vis_last_i) begin
        w_commit[r_wbank] = 1'b1;
        w_clen[r_wbank]   = w_wcnt_n;
        w_wbank_n         = ~r_wbank;
        w_wstate_n        = W_IDLE;
      end
    end else if (w_acc && (r_wstate == W_DROP) && vis_last_i) begin
      w_wstate_n = W_IDLE;
    end
  end

  // r_q always holds the word after the one on the output, so a handshake never waits on the SRAM.
  always_comb begin
    w_rstate_n  = r_rstate;
    w_re        = 1'b0;
    w_rbank_sel = r_rbank;
    w_raddr     = r_rptr;
    w_load      = 1'b0;
    w_oidx_n    = r_oidx + LEN_ONE;
    w_rel       = 1'b0;
    case (r_rstate)
      R_IDLE: if (r_full[r_rbank]) begin
        w_re       = 1'b1;
        w_raddr    = '0;
        w_rstate_n = R_FETCH;
      end
      R_FETCH: begin
        w_load     = 1'b1;
        w_oidx_n   = '0;
        w_re       = 1'b1;
        w_raddr    = LEN_ONE;
        w_rstate_n = R_SEND;
      end
      R_SEND: if (r_tvalid && m_tready) begin
        if (r_tlast) begin
          w_rel       = 1'b1;
          w_rbank_sel = ~r_rbank;
          if (r_full[~r_rbank]) begin
            w_re       = 1'b1;
            w_raddr    = '0;
            w_rstate_n = R_FETCH;
          end else begin
            w_rstate_n = R_IDLE;
          end
        end else begin
          w_load = 1'b1;
          w_re   = 1'b1;
        end
      end
      default: w_rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_idx] <= {vis_real_i, vis_imag_i};
    if (w_re && (w_raddr < LEN_MAX)) r_q <= r_mem[f_idx(w_rbank_sel, w_raddr)];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate   <= W_IDLE;
      r_wbank    <= 1'b0;
      r_wcnt     <= '0;
      r_full     <= '0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_overflow <= 1'b0;
      r_rstate   <= R_IDLE;
      r_rbank    <= 1'b0;
      r_rptr     <= '0;
      r_oidx     <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else begin
      r_wstate <= w_wstate_n;
      r_wbank  <= w_wbank_n;
      r_wcnt   <= w_wcnt_n;
      // A commit to a just-released bank must win over the release.
      if (w_rel) r_full[r_rbank] <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        if (w_commit[b]) begin
          r_full[b] <= 1'b1;
          r_len[b]  <= w_clen[b];
        end
      end
      if (w_drop) r_overflow <= 1'b1;
      r_rstate <= w_rstate_n;
      if (w_re) r_rptr <= w_raddr + LEN_ONE;
      if (w_load) begin
        r_tdata  <= r_q;
        r_tvalid <= 1'b1;
        r_oidx   <= w_oidx_n;
        r_tlast  <= ((w_oidx_n + LEN_ONE) == r_len[r_rbank]);
      end
      if (w_rel) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_rbank  <= ~r_rbank;
      end
    end
  end

  assign m_tvalid   = r_tvalid;
  assign m_tlast    = r_tlast;
  assign m_tdata    = r_tdata;
  assign overflow_o = r_overflow;

`ifdef VISREADER_DROP_COUNT_EN
  logic [7:0] r_drops;
  always_ff @(posedge clock) begin
    if (reset) r_drops <= '0;
    else if (w_drop && (r_drops != 8'hFF)) r_drops <= r_drops + 8'd1;
  end
  assign drops_o = r_drops;
`endif
endmodule

// File: tb/tb_visreader.sv
// tb_visreader: directed frames against hand-computed word lists for visreader.
// Handshaked words are collected by a negedge monitor that also checks output stability during stalls.
module tb_visreader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vis_frame_i = 1'b1;
  logic        vis_valid_i = 1'b0;
  logic        vis_first_i = 1'b0;
  logic        vis_last_i  = 1'b0;
  logic [6:0]  vis_real_i  = '0;
  logic [6:0]  vis_imag_i  = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [13:0] m_tdata;
  logic        overflow_o;
`ifdef VISREADER_DROP_COUNT_EN
  logic [7:0]  drops_o;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [14:0] q[$];
  logic        p_stall = 1'b0;
  logic        p_rst = 1'b1;
  logic [13:0] p_data = '0;
  logic        p_last = 1'b0;

  visreader #(.WIDTH(7), .COUNT(15)) dut (
    .clock(clock), .reset(reset),
    .vis_frame_i(vis_frame_i), .vis_valid_i(vis_valid_i),
    .vis_first_i(vis_first_i), .vis_last_i(vis_last_i),
    .vis_real_i(vis_real_i), .vis_imag_i(vis_imag_i),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .overflow_o(overflow_o)
`ifdef VISREADER_DROP_COUNT_EN
    , .drops_o(drops_o)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
    if (p_stall && !p_rst) begin
      check("hold_valid", {31'b0, m_tvalid}, 32'd1);
      check("hold_data", {18'b0, m_tdata}, {18'b0, p_data});
      check("hold_last", {31'b0, m_tlast}, {31'b0, p_last});
    end
    p_stall = m_tvalid && !m_tready;
    p_rst   = reset;
    p_data  = m_tdata;
    p_last  = m_tlast;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    vis_valid_i = 1'b0;
    vis_first_i = 1'b0;
    vis_last_i  = 1'b0;
    vis_frame_i = 1'b1;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    q.delete();
  endtask

  // Word i of a frame: real = seed+i, imag = 15-i; junk_at inserts an out-of-frame word before word junk_at.
  task automatic send_frame(input int seed, input int n, input int junk_at);
    for (int i = 0; i < n; i++) begin
      if (i == junk_at) begin
        vis_frame_i = 1'b0; vis_valid_i = 1'b1; vis_first_i = 1'b1; vis_last_i = 1'b1;
        vis_real_i = 7'h7f; vis_imag_i = 7'h7f;
        tick();
        vis_frame_i = 1'b1;
      end
      vis_valid_i = 1'b1;
      vis_first_i = (i == 0);
      vis_last_i  = (i == n - 1);
      vis_real_i  = 7'(seed + i);
      vis_imag_i  = 7'(15 - i);
      tick();
    end
    idle_in();
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while ((q.size() < n) && (c < budget)) begin
      tick();
      c++;
    end
    check({tag, "_count"}, q.size(), n);
  endtask

  task automatic compare_frame(input int seed, input int n, input string tag);
    logic [6:0]  re, im;
    logic [31:0] exp, got;
    for (int i = 0; i < n; i++) begin
      re  = 7'(seed + i);
      im  = 7'(15 - i);
      exp = {17'b0, (i == n - 1), re, im};
      got = (q.size() != 0) ? {17'b0, q.pop_front()} : 32'hFFFF_FFFF;
      check($sformatf("%s_w%0d", tag, i), got, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and single frame latency/throughput
    do_reset();
    check("rst_valid", {31'b0, m_tvalid}, 32'd0);
    check("rst_last", {31'b0, m_tlast}, 32'd0);
    check("rst_data", {18'b0, m_tdata}, 32'd0);
    check("rst_ovf", {31'b0, overflow_o}, 32'd0);
    m_tready = 1'b1;
    send_frame(0, 15, -1);
    check("lat_0", {31'b0, m_tvalid}, 32'd0);
    tick();
    check("lat_1", {31'b0, m_tvalid}, 32'd0);
    tick();
    check("lat_2", {31'b0, m_tvalid}, 32'd1);
    repeat (15) tick();
    check("thru_count", q.size(), 15);
    check("thru_end_valid", {31'b0, m_tvalid}, 32'd0);
    compare_frame(0, 15, "single");

    // Backpressure: ready toggles every cycle
    do_reset();
    m_tready = 1'b0;
    send_frame(3, 15, -1);
    for (int c = 0; (c < 80) && (q.size() < 15); c++) begin
      m_tready = ~m_tready;
      tick();
    end
    check("bp_count", q.size(), 15);
    compare_frame(3, 15, "bp");
    check("bp_ovf", {31'b0, overflow_o}, 32'd0);

    // Overflow: A, B captured, C dropped while ready is low
    do_reset();
    m_tready = 1'b0;
    send_frame(10, 15, -1);
    send_frame(40, 4, -1);
    send_frame(70, 5, -1);
    check("ovf_flag", {31'b0, overflow_o}, 32'd1);
`ifdef VISREADER_DROP_COUNT_EN
    check("ovf_drops", {24'b0, drops_o}, 32'd1);
`endif
    m_tready = 1'b1;
    wait_q(19, 80, "ovf");
    compare_frame(10, 15, "ovf_a");
    compare_frame(40, 4, "ovf_b");
    repeat (8) tick();
    check("ovf_no_c", q.size(), 0);
    check("ovf_idle", {31'b0, m_tvalid}, 32'd0);

    // Short frame (with an out-of-frame word mixed in) and oversize frame
    do_reset();
    m_tready = 1'b1;
    send_frame(60, 4, 2);
    send_frame(90, 20, -1);
    wait_q(19, 80, "size");
    compare_frame(60, 4, "short");
    compare_frame(90, 15, "over");
    repeat (5) tick();
    check("over_extra", q.size(), 0);

    // Same-cycle release: W flushes through bank 0, then B (bank 1), A (bank 0), C into B's bank
    do_reset();
    m_tready = 1'b1;
    send_frame(5, 2, -1);
    wait_q(2, 20, "rel_w");
    compare_frame(5, 2, "rel_w");
    m_tready = 1'b0;
    send_frame(20, 3, -1);
    send_frame(30, 3, -1);
    repeat (3) tick();
    m_tready = 1'b1;
    tick();
    tick();
    check("rel_tlast", {31'b0, m_tlast}, 32'd1);
    send_frame(50, 3, -1);
    wait_q(9, 60, "rel");
    check("rel_ovf", {31'b0, overflow_o}, 32'd0);
    compare_frame(20, 3, "rel_b");
    compare_frame(30, 3, "rel_a");
    compare_frame(50, 3, "rel_c");

    // Reset mid-readout at word 7
    do_reset();
    m_tready = 1'b1;
    send_frame(17, 15, -1);
    wait_q(7, 40, "mid");
    reset = 1'b1;
    tick();
    check("mid_valid", {31'b0, m_tvalid}, 32'd0);
    check("mid_last", {31'b0, m_tlast}, 32'd0);
    check("mid_data", {18'b0, m_tdata}, 32'd0);
    check("mid_ovf", {31'b0, overflow_o}, 32'd0);
    tick();
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      vis_valid_i = 1'b1;
      vis_first_i = 1'b0;
      vis_last_i  = (i == 2);
      vis_real_i  = 7'(100 + i);
      vis_imag_i  = 7'(i);
      tick();
    end
    idle_in();
    repeat (6) tick();
    check("mid_nofirst_valid", {31'b0, m_tvalid}, 32'd0);
    check("mid_nofirst_q", q.size(), 0);
    send_frame(33, 15, -1);
    wait_q(15, 40, "mid_next");
    compare_frame(33, 15, "mid_next");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
